// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the requesters and the round-robin mux arbiter.
//   req  : request per requester (bit i = requester i)
//   d    : data bit per requester
//   gnt  : one-hot grant, zero when idle
//   sel  : binary index of the granted requester
//   busy : a grant is active
//   y    : shared mux output, d[sel] while busy
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  // Requester side drives requests and data, observes the grant.
  modport master (
    output req, d,
    input  gnt, sel, busy, y
  );

  // Arbiter side.
  modport slave (
    input  req, d,
    output gnt, sel, busy, y
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 single-bit mux.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux4_rr_arbiter_if (req/d in, gnt/sel/busy/y out)
// Parameter MAX_HOLD (1..255) bounds how many consecutive cycles one owner
// keeps the mux while another requester is waiting.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               busy_q, busy_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         others;
  logic [2:0]         pick_all;
  logic [2:0]         pick_oth;
  logic               take;
  logic [1:0]         win;

  // Returns {found, index} of the first set candidate after ptr, wrapping;
  // ptr itself is examined last so it has lowest priority.
  function automatic logic [2:0] pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Requests from everyone except the current owner.
  assign others   = bus.req & ~(4'b0001 << sel_q);
  assign pick_all = pick(bus.req, last_q);
  assign pick_oth = pick(others, last_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitration, release, and hold-limit rotation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    win     = 2'b00;

    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          take = 1'b1;
          win  = pick_all[1:0];
        end
      end
      OWNED: begin
        if (!bus.req[sel_q]) begin
          // Release; the owner's bit is already clear, so others == req.
          if (pick_oth[2]) begin
            take = 1'b1;
            win  = pick_oth[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt_q < CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (pick_oth[2]) begin
          take = 1'b1;
          win  = pick_oth[1:0];
        end else begin
          // Limit reached but nobody waiting: keep the mux, restart the count.
          cnt_d = CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      state_d = OWNED;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      busy_d  = 1'b1;
      last_d  = win;
      cnt_d   = CNT_W'(1);
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  // Shared mux path; sel is always a valid 2-bit index.
  assign bus.y    = busy_q & bus.d[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: two instances (MAX_HOLD 8 and 2)
// share the same stimulus and are compared against an owner/pointer model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_v;
  logic [3:0] d_v;

  int n_checks;
  int n_errors;

  mux4_rr_arbiter_if bus8 ();
  mux4_rr_arbiter_if bus2 ();

  assign bus8.req = req_v;
  assign bus8.d   = d_v;
  assign bus2.req = req_v;
  assign bus2.d   = d_v;

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mux4_rr_arbiter #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner (-1 = idle), last owner, cycles held so far.
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int m_sel   [2];
  int m_max   [2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t vecs [24];

  function automatic int win_from(int last, logic [3:0] cand);
    for (int k = 1; k <= 4; k++) begin
      if (cand[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 3;
      m_held[i]  = 0;
      m_sel[i]   = 0;
    end
  endtask

  task automatic model_grant(int i, int w);
    m_owner[i] = w;
    m_last[i]  = w;
    m_sel[i]   = w;
    m_held[i]  = 1;
  endtask

  task automatic model_step(int i, logic [3:0] r);
    int w;
    logic [3:0] oth;
    if (m_owner[i] < 0) begin
      w = win_from(m_last[i], r);
      if (w >= 0) model_grant(i, w);
    end else if (!r[m_owner[i]]) begin
      w = win_from(m_last[i], r);
      if (w >= 0) model_grant(i, w);
      else begin
        m_owner[i] = -1;
        m_held[i]  = 0;
      end
    end else if (m_held[i] < m_max[i]) begin
      m_held[i]++;
    end else begin
      oth = r;
      oth[m_owner[i]] = 1'b0;
      w = win_from(m_last[i], oth);
      if (w >= 0) model_grant(i, w);
      else m_held[i] = 1;
    end
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(int i, string tag);
    logic [3:0] ag, eg;
    logic [1:0] as, es;
    logic       ab, eb, ay, ey;
    if (i == 0) begin
      ag = bus8.gnt; as = bus8.sel; ab = bus8.busy; ay = bus8.y;
    end else begin
      ag = bus2.gnt; as = bus2.sel; ab = bus2.busy; ay = bus2.y;
    end
    eb = (m_owner[i] >= 0);
    eg = eb ? (4'b0001 << m_owner[i]) : 4'b0000;
    es = 2'(m_sel[i]);
    ey = eb ? d_v[m_sel[i]] : 1'b0;
    check($sformatf("%s h%0d gnt", tag, m_max[i]), 8'(ag), 8'(eg));
    check($sformatf("%s h%0d sel", tag, m_max[i]), 8'(as), 8'(es));
    check($sformatf("%s h%0d busy", tag, m_max[i]), 8'(ab), 8'(eb));
    check($sformatf("%s h%0d y", tag, m_max[i]), 8'(ay), 8'(ey));
  endtask

  // Drive inputs, clock once, advance the model, compare both instances.
  task automatic step(logic [3:0] r, logic [3:0] dd, string tag);
    req_v = r;
    d_v   = dd;
    @(posedge clk);
    model_step(0, r);
    model_step(1, r);
    #1;
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_max[0] = 8;
    m_max[1] = 2;
    model_reset();

    // Expected values for the MAX_HOLD=2 instance, from reset.
    vecs[0]  = '{4'b1111, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[1]  = '{4'b1111, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[2]  = '{4'b1111, 4'b0101, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0101, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0101, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0101, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[10] = '{4'b1111, 4'b0101, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{4'b0010, 4'b0101, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[12] = '{4'b1001, 4'b0101, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[13] = '{4'b0000, 4'b0101, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[14] = '{4'b0000, 4'b0101, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[15] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[16] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[17] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[18] = '{4'b0011, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[19] = '{4'b0011, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[20] = '{4'b0011, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[21] = '{4'b0010, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[22] = '{4'b0011, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[23] = '{4'b0011, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    req_v = 4'b0000;
    d_v   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_dut(0, "reset");
    check_dut(1, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: round robin, release handoff, idle, hold-limit corner cases.
    for (int v = 0; v < 24; v++) begin
      step(vecs[v].req, vecs[v].d, $sformatf("vec%0d", v));
      check($sformatf("vec%0d tbl gnt", v), 8'(bus2.gnt), 8'(vecs[v].gnt));
      check($sformatf("vec%0d tbl sel", v), 8'(bus2.sel), 8'(vecs[v].sel));
      check($sformatf("vec%0d tbl busy", v), 8'(bus2.busy), 8'(vecs[v].busy));
      check($sformatf("vec%0d tbl y", v), 8'(bus2.y), 8'(vecs[v].y));
    end

    // Reset asserted mid-grant takes effect without a clock edge.
    step(4'b1111, 4'b1111, "pre_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_dut(0, "async_rst");
    check_dut(1, "async_rst");
    check("async_rst busy8", 8'(bus8.busy), 8'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_dut(0, "rst_hold");
      check_dut(1, "rst_hold");
    end
    req_v = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b1111, "post_rst_idle");
    step(4'b0000, 4'b1111, "post_rst_idle");
    // Pointer back at 3: requester 0 wins first.
    step(4'b1111, 4'b1111, "post_rst_ptr");
    check("post_rst_ptr gnt8", 8'(bus8.gnt), 8'b0001);
    check("post_rst_ptr gnt2", 8'(bus2.gnt), 8'b0001);

    // Uncontended hold for 20 cycles.
    step(4'b0000, 4'b0000, "unc_idle");
    for (int c = 0; c < 20; c++) begin
      step(4'b0001, 4'(c), "unc_hold");
      check("unc_hold gnt8", 8'(bus8.gnt), 8'b0001);
      check("unc_hold gnt2", 8'(bus2.gnt), 8'b0001);
    end

    // Data path: owner 2, y follows d[2] combinationally.
    step(4'b0000, 4'b0000, "dp_idle");
    step(4'b0100, 4'b0000, "dp_grant");
    for (int c = 0; c < 16; c++) begin
      logic [3:0] nd;
      nd    = 4'($urandom_range(0, 15));
      nd[2] = ~d_v[2];
      d_v   = nd;
      #1;
      check("dp y8", 8'(bus8.y), 8'(nd[2]));
      check("dp y2", 8'(bus2.y), 8'(nd[2]));
      step(4'b0100, nd, "dp_step");
    end

    // Randomized stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 1) == 0) ? req_v : 4'($urandom_range(0, 15));
      step(r, 4'($urandom_range(0, 15)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares a 4:1 single-bit mux among four requesters. It registers a one-hot grant, drives the matching 2-bit mux select, and routes the granted requester's data bit to the shared output. A per-grant hold limit bounds how long one requester keeps the mux while others wait. The block sits in front of the existing 4:1 mux datapath as its select controller and contains its own select-to-data path.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 1..255
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request per requester; bit i = requester i
- d  input  4  data bit per requester; d[i] belongs to requester i
- gnt  output  4  registered one-hot grant, all-zero when idle
- sel  output  2  registered mux select, binary index of the granted requester
- busy  output  1  registered; 1 when any grant is active
- y  output  1  combinational: d[sel] when busy, else 0

## Operation
- State machine: IDLE and OWNED.
- Priority pointer `last` (2 bits) holds the index of the most recent owner. Search order starts at last+1 and wraps modulo 4, so the previous owner has lowest priority.
- IDLE: if req != 0, take the winner by search order. Go to OWNED with gnt = one-hot(winner), sel = winner, last = winner, hold count = 1. If req == 0, stay in IDLE with all outputs at their reset values.
- OWNED: req[sel] = 0 means release.
  - Release with other requests pending: switch directly to the next winner, with no idle cycle.
  - Release with no other requests: go to IDLE, gnt = 0, busy = 0. sel keeps its last value.
- OWNED, req[sel] = 1 and hold count < MAX_HOLD: keep the grant and increment the count.
- OWNED, req[sel] = 1 and hold count = MAX_HOLD:
  - Another request pending: rotate to the next winner, excluding the current owner, and reset the count to 1.
  - No other request pending: keep the grant and reset the count to 1. There is no forced idle.
- Hold count width: $clog2(MAX_HOLD+1). The count saturates logic per the rules above and never wraps.
- Simultaneous release by the owner and new request by the same requester in one cycle: counts as a release. That requester competes again at lowest priority.
- All outputs except y are registered. y is the mux path only: no latch, no default-less case. Unknown sel values are impossible by construction.

## Timing
- Reset (rst_n low, asynchronous): gnt = 4'b0000, sel = 2'b00, busy = 0, last = 2'd3 (so requester 0 has first priority), count = 0, state = IDLE, y = 0.
- Deassertion of reset is synchronous to clk, handled by the top-level synchronizer. The first arbitration occurs on the first rising edge with rst_n high.
- Grant latency: a request sampled high at edge N with the block idle gives gnt/sel/busy valid after edge N.
- Release latency: req[sel] sampled low at edge N gives the new grant or idle after edge N. The old owner never keeps the grant past that edge.
- Hold limit: while contended, an owner holds the grant for exactly MAX_HOLD consecutive cycles.
- Reset asserted mid-grant: outputs go to reset values immediately, without waiting for clk. The pointer returns to 3.
- gnt is always one-hot or zero. When busy = 1, gnt[sel] = 1.

## Test plan
- Reset and idle: assert rst_n = 0 mid-grant, then release with req = 0 -> gnt = 0000, sel = 00, busy = 0, y = 0 immediately and held.
- Single requester: req = 0100, d = 0100 -> one edge later gnt = 0100, sel = 10, busy = 1, y = 1. Then drop req -> gnt = 0000 after the next edge.
- Round robin: req = 1111 held, MAX_HOLD = 2 -> owners 0,0,1,1,2,2,3,3,0 in successive cycles. Each grant change coincides with sel = 0,1,2,3,0.
- Release handoff: owner 1, req goes 0010 -> 1001 in one cycle -> the next edge grants 3 (search from 2), with no idle cycle and busy staying 1.
- Uncontended hold: req = 0001 held for 20 cycles, MAX_HOLD = 8 -> gnt stays 0001 throughout and the count reloads every 8 cycles.
- Data path: owner 2, toggle d[2] every cycle and d[0], d[1], d[3] randomly -> y tracks d[2] combinationally. No other bit reaches y.
